// File: rtl/chacha_block_sched_pkg.sv
// Shared ChaCha definitions: quarter-round sub-step codes, FSM states and
// the column/diagonal word-index mapping.
package chacha_defs;

  localparam int ROUNDS_DEF = 20;
  localparam int NUM_LANES  = 4;
  localparam int VEC_W      = 32;

  // Each code selects one add/xor/rotate line of the quarter round.
  typedef enum logic [1:0] {
    SR_AB16 = 2'd0,  // a += b; d ^= a; d <<<= 16
    SR_CD12 = 2'd1,  // c += d; b ^= c; b <<<= 12
    SR_AB8  = 2'd2,  // a += b; d ^= a; d <<<= 8
    SR_CD7  = 2'd3   // c += d; b ^= c; b <<<= 7
  } sr_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ADD   = 2'd2
  } state_e;

  typedef logic [NUM_LANES-1:0][VEC_W-1:0] lanes_t;

  // Lane j of quarter round i reads row j; column passes use column i,
  // diagonal passes shift column by j (2-bit add wraps mod 4).
  function automatic logic [3:0] qr_idx(input logic half, input logic [1:0] qr,
                                        input logic [1:0] lane);
    logic [1:0] col;
    col = half ? 2'(qr + lane) : qr;
    return {lane, col};
  endfunction

endpackage

// File: rtl/chacha_block_sched_qr.sv
// ChaCha quarter-round datapath, one add/xor/rotate line per call,
// selected by sr_sel. Lanes are (a, b, c, d) = x[0..3].
module chacha_qr
  import chacha_defs::*;
(
  input  logic [1:0] sr_sel,
  input  lanes_t     x,
  output lanes_t     y
);

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  always_comb begin
    y = x;
    case (sr_sel)
      SR_AB16: begin y[0] = x[0] + x[1]; y[3] = rotl(x[3] ^ y[0], 16); end
      SR_CD12: begin y[2] = x[2] + x[3]; y[1] = rotl(x[1] ^ y[2], 12); end
      SR_AB8:  begin y[0] = x[0] + x[1]; y[3] = rotl(x[3] ^ y[0], 8);  end
      SR_CD7:  begin y[2] = x[2] + x[3]; y[1] = rotl(x[1] ^ y[2], 7);  end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/chacha_block_sched.sv
// ChaCha block scheduler: loads a 16-word state, runs ROUNDS rounds through a
// single shared quarter-round unit, then adds the input state back.
module chacha_block_sched
  import chacha_defs::*;
#(
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        start,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done
);

  localparam int DR_LAST = ROUNDS / 2 - 1;
  localparam int DRW     = (ROUNDS / 2 > 1) ? $clog2(ROUNDS / 2) : 1;

  state_e                state_q, state_d;
  logic [15:0][31:0]     in_buf, work;
  logic [1:0]            sub, qr;
  logic                  half;
  logic [DRW-1:0]        dr;
  logic [3:0]            add_k;
  logic [NUM_LANES-1:0][3:0] sel;
  lanes_t                qr_x, qr_y;
  logic                  round_last, add_last, done_q;

  always_comb begin
    for (int j = 0; j < NUM_LANES; j++) begin
      sel[j]  = qr_idx(half, qr, 2'(j));
      qr_x[j] = work[sel[j]];
    end
  end

  chacha_qr u_qr (
    .sr_sel (sub),
    .x      (qr_x),
    .y      (qr_y)
  );

  assign round_last = (dr == DRW'(DR_LAST)) && half && (qr == 2'd3) && (sub == 2'd3);
  assign add_last   = (add_k == 4'd15);
  assign rd_data    = work[rd_addr];
  assign done       = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:  if (start)      state_d = ST_ROUND;
      ST_ROUND: if (round_last) state_d = ST_ADD;
      ST_ADD:   if (add_last)   state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_buf <= '0;
      work   <= '0;
      sub    <= '0;
      qr     <= '0;
      half   <= 1'b0;
      dr     <= '0;
      add_k  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == ST_ADD) && add_last;
      case (state_q)
        ST_IDLE: begin
          sub   <= '0;
          qr    <= '0;
          half  <= 1'b0;
          dr    <= '0;
          add_k <= '0;
          if (wr_en) begin
            in_buf[wr_addr] <= wr_data;
            work[wr_addr]   <= wr_data;
          end
          // Reload from in_buf so a restart never chains off a previous result;
          // a same-cycle write is folded in.
          if (start) begin
            for (int k = 0; k < 16; k++)
              work[k] <= (wr_en && wr_addr == 4'(k)) ? wr_data : in_buf[k];
          end
        end
        ST_ROUND: begin
          for (int j = 0; j < NUM_LANES; j++)
            work[sel[j]] <= qr_y[j];
          sub <= sub + 2'd1;
          if (sub == 2'd3) begin
            qr <= qr + 2'd1;
            if (qr == 2'd3) begin
              half <= ~half;
              if (half) dr <= dr + DRW'(1);
            end
          end
        end
        ST_ADD: begin
          work[add_k] <= work[add_k] + in_buf[add_k];
          add_k       <= add_k + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_sched.sv
// Directed bench for chacha_block_sched: RFC 8439 block vector, zero state,
// ignored mid-run inputs, mid-run reset, back-to-back start, ChaCha8 build.
`timescale 1ns/1ps
module tb_chacha_block_sched;

  typedef logic [15:0][31:0] blk_t;
  typedef struct {
    logic [3:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic        start8 = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data, rd_data8;
  logic        busy, done, busy8, done8;

  int errors = 0;
  int checks = 0;
  vec_t rfc[16];
  blk_t vin, vout, v8;

  always #5 clk = ~clk;

  chacha_block_sched dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
  );

  chacha_block_sched #(.ROUNDS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start8), .rd_addr(rd_addr), .rd_data(rd_data8), .busy(busy8), .done(done8)
  );

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic void mqr(inout blk_t x, input int a, input int b, input int c, input int d);
    x[a] = x[a] + x[b]; x[d] = rol(x[d] ^ x[a], 16);
    x[c] = x[c] + x[d]; x[b] = rol(x[b] ^ x[c], 12);
    x[a] = x[a] + x[b]; x[d] = rol(x[d] ^ x[a], 8);
    x[c] = x[c] + x[d]; x[b] = rol(x[b] ^ x[c], 7);
  endfunction

  function automatic blk_t model(input blk_t s, input int rounds);
    blk_t x;
    x = s;
    for (int r = 0; r < rounds / 2; r++) begin
      mqr(x, 0, 4, 8, 12); mqr(x, 1, 5, 9, 13); mqr(x, 2, 6, 10, 14); mqr(x, 3, 7, 11, 15);
      mqr(x, 0, 5, 10, 15); mqr(x, 1, 6, 11, 12); mqr(x, 2, 7, 8, 13); mqr(x, 3, 4, 9, 14);
    end
    for (int k = 0; k < 16; k++) x[k] = x[k] + s[k];
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input blk_t b);
    for (int k = 0; k < 16; k++) begin
      wr_en = 1'b1; wr_addr = 4'(k); wr_data = b[k];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic check_words(input string name, input blk_t exp, input bit use8);
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      #1;
      check($sformatf("%s[%0d]", name, k), use8 ? rd_data8 : rd_data, exp[k]);
    end
  endtask

  // Starts a block and returns in the cycle done is seen; lat=-1 on timeout.
  // At cycle 'inject' a start plus a write to word 0 is pulsed.
  task automatic run(input bit use8, input int inject, output int lat, output int bcnt);
    int n;
    if (use8) start8 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0; start8 = 1'b0;
    n = 1; bcnt = 0; lat = -1;
    while (n < 1000) begin
      if (use8 ? done8 : done) begin lat = n; break; end
      if (use8 ? busy8 : busy) bcnt++;
      if (n == inject) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hdeadbeef;
      end
      tick();
      start = 1'b0; wr_en = 1'b0;
      n++;
    end
  endtask

  initial begin
    int lat, bcnt;
    rfc[0]  = '{4'd0,  32'h61707865, 32'he4e7f110};
    rfc[1]  = '{4'd1,  32'h3320646e, 32'h15593bd1};
    rfc[2]  = '{4'd2,  32'h79622d32, 32'h1fdd0f50};
    rfc[3]  = '{4'd3,  32'h6b206574, 32'hc47120a3};
    rfc[4]  = '{4'd4,  32'h03020100, 32'hc7f4d1c7};
    rfc[5]  = '{4'd5,  32'h07060504, 32'h0368c033};
    rfc[6]  = '{4'd6,  32'h0b0a0908, 32'h9aaa2204};
    rfc[7]  = '{4'd7,  32'h0f0e0d0c, 32'h4e6cd4c3};
    rfc[8]  = '{4'd8,  32'h13121110, 32'h466482d2};
    rfc[9]  = '{4'd9,  32'h17161514, 32'h09aa9f07};
    rfc[10] = '{4'd10, 32'h1b1a1918, 32'h05d7c214};
    rfc[11] = '{4'd11, 32'h1f1e1d1c, 32'ha2028bd9};
    rfc[12] = '{4'd12, 32'h00000001, 32'hd19c12b5};
    rfc[13] = '{4'd13, 32'h09000000, 32'hb94e16de};
    rfc[14] = '{4'd14, 32'h4a000000, 32'he883d0cb};
    rfc[15] = '{4'd15, 32'h00000000, 32'h4e3c50a2};
    for (int k = 0; k < 16; k++) begin
      vin[rfc[k].addr]  = rfc[k].din;
      vout[rfc[k].addr] = rfc[k].dout;
    end
    v8 = model(vin, 8);

    // reset state
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_words("rst_rd", '0, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: RFC 8439 vector, table driven
    for (int k = 0; k < 16; k++) begin
      wr_en = 1'b1; wr_addr = rfc[k].addr; wr_data = rfc[k].din;
      tick();
    end
    wr_en = 1'b0;
    run(1'b0, -1, lat, bcnt);
    check("t1_latency", 32'(lat), 32'd337);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);
    for (int k = 0; k < 16; k++) begin
      rd_addr = rfc[k].addr;
      #1;
      check($sformatf("t1_word[%0d]", k), rd_data, rfc[k].dout);
    end

    // 2: all-zero state
    load('0);
    run(1'b0, -1, lat, bcnt);
    check("t2_latency", 32'(lat), 32'd337);
    check("t2_busy_cycles", 32'(bcnt), 32'd336);
    check_words("t2_word", '0, 1'b0);

    // 3: start and write at cycle 100 are ignored
    load(vin);
    run(1'b0, 100, lat, bcnt);
    check("t3_latency", 32'(lat), 32'd337);
    check_words("t3_word", vout, 1'b0);

    // 4: reset at cycle 150 aborts, then a clean reload recomputes
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (149) tick();
    check("t4_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check_words("t4_rd_zero", '0, 1'b0);
    rst_n = 1'b1;
    tick();
    load(vin);
    run(1'b0, -1, lat, bcnt);
    check("t4_latency", 32'(lat), 32'd337);
    check_words("t4_word", vout, 1'b0);

    // 5: restart from an old result, then start again in the done cycle
    run(1'b0, -1, lat, bcnt);
    check("t5a_latency", 32'(lat), 32'd337);
    run(1'b0, -1, lat, bcnt);
    check("t5b_latency", 32'(lat), 32'd337);
    check_words("t5_word", vout, 1'b0);

    // 6: ChaCha8 build against the reference model
    run(1'b1, -1, lat, bcnt);
    check("t6_latency", 32'(lat), 32'd145);
    check("t6_busy_cycles", 32'(bcnt), 32'd144);
    check_words("t6_word", v8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
